cd_host_if: RTL and testbench

// - Host-side register interface of the CD block, sitting on the SCU A-bus CS2 window (A[25:16]=10'h189).
// - Exposes HIRQ/HIRQMASK/CR1-4 to the SH-2s through the SCU.
// - Hands 4x16-bit commands to the CD back-end over a valid/ready handshake and latches its responses.
// - Drives the A-bus interrupt line (SCU AIRQ_N) from HIRQ & HIRQMASK.

---
 rtl/cd_pkg.sv | 29 ++
 rtl/cd_host_if.sv | 188 ++++++++++++++++++
 tb/tb_cd_host_if.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cd_pkg.sv
// Shared constants and types for the CD block host register interface.
package cd_pkg;

   localparam int unsigned CMD_W    = 64;
   localparam int unsigned WORD_W   = 16;
   localparam int unsigned CNT_W    = 18;
   localparam int unsigned CMOK_BIT = 0;

   localparam logic [9:0]  CS2_BASE = 10'h189;

   localparam logic [WORD_W-1:0] OFS_HIRQ     = 16'h0008;
   localparam logic [WORD_W-1:0] OFS_HIRQMASK = 16'h000C;
   localparam logic [WORD_W-1:0] OFS_CR1      = 16'h0018;
   localparam logic [WORD_W-1:0] OFS_CR2      = 16'h001C;
   localparam logic [WORD_W-1:0] OFS_CR3      = 16'h0020;
   localparam logic [WORD_W-1:0] OFS_CR4      = 16'h0024;

   // "CDBLOCK" signature shown in CR1..CR4 after reset
   localparam logic [CMD_W-1:0] CR_RST = 64'h0043_4442_4C4F_434B;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} cd_if_state_t;

   function automatic logic [WORD_W-1:0] lane_merge(input logic [WORD_W-1:0] old_v,
                                                    input logic [WORD_W-1:0] new_v,
                                                    input logic [WORD_W-1:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

endpackage

// File: rtl/cd_host_if.sv
// Host-side HIRQ/HIRQMASK/CR register window of the CD block with command handshake.
// Optional periodic status report into CR enabled by CD_PERIODIC_REPORT_EN.
module cd_host_if
   import cd_pkg::*;
#(
   parameter int unsigned PERIOD_CYC = 238000
)(
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CE_R,
   input  logic [25:1]         A,
   input  logic [WORD_W-1:0]   DI,
   output logic [WORD_W-1:0]   DO,
   input  logic                CS_N,
   input  logic                RD_N,
   input  logic                WRU_N,
   input  logic                WRL_N,
   output logic                IRQ_N,
   output logic                CMD_VALID,
   output logic [CMD_W-1:0]    CMD,
   input  logic                CMD_READY,
   input  logic                RESP_VALID,
   input  logic [CMD_W-1:0]    RESP,
   input  logic [WORD_W-1:0]   RESP_HIRQ,
   input  logic [CMD_W-1:0]    STATUS
);

   cd_if_state_t        state_q, state_d;
   logic [WORD_W-1:0]   hirq_q, hirq_d;
   logic [WORD_W-1:0]   mask_q, mask_d;
   logic [CMD_W-1:0]    cr_q, cr_d;
   logic [CMD_W-1:0]    latch_q, latch_d;
   logic [CMD_W-1:0]    cmd_q, cmd_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic                irq_n_q, irq_n_d;

   logic                hit_c;
   logic [WORD_W-1:0]   ofs_c;
   logic [WORD_W-1:0]   wm_c;
   logic                wr_c;
   logic                wr_cr4_c;
   logic                unused_c;

   assign hit_c    = !CS_N && (A[25:16] == CS2_BASE);
   assign ofs_c    = {A[15:1], 1'b0};
   assign wm_c     = {{8{~WRU_N}}, {8{~WRL_N}}};
   assign wr_c     = hit_c && (|wm_c);
   assign wr_cr4_c = wr_c && (ofs_c == OFS_CR4);

`ifdef CD_PERIODIC_REPORT_EN
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYC - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             report_c;

   // Idle-time counter; any activity restarts the report period
   always_comb begin
      cnt_d = '0;
      if (state_q == IDLE) begin
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   assign report_c = (state_q == IDLE) && (cnt_q == CNT_LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_q <= '0;
      end else if (CE_R) begin
         cnt_q <= cnt_d;
      end
   end

   assign unused_c = RD_N;
`else
   assign unused_c = ^{RD_N, STATUS, 32'(PERIOD_CYC)};
`endif

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
      end else if (CE_R) begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (wr_cr4_c)                   state_d = ISSUE;
         ISSUE:   if (cmd_valid_q && CMD_READY)   state_d = WAIT;
         WAIT:    if (RESP_VALID)                 state_d = IDLE;
         default:                                 state_d = IDLE;
      endcase
   end

   // Register/datapath updates; response set bits are applied after host clears
   always_comb begin
      hirq_d      = hirq_q;
      mask_d      = mask_q;
      cr_d        = cr_q;
      latch_d     = latch_q;
      cmd_d       = cmd_q;
      cmd_valid_d = cmd_valid_q;

      if (wr_c) begin
         case (ofs_c)
            OFS_HIRQ:     hirq_d          = hirq_q & (DI | ~wm_c);
            OFS_HIRQMASK: mask_d          = lane_merge(mask_q, DI, wm_c);
            OFS_CR1:      latch_d[63:48]  = lane_merge(latch_q[63:48], DI, wm_c);
            OFS_CR2:      latch_d[47:32]  = lane_merge(latch_q[47:32], DI, wm_c);
            OFS_CR3:      latch_d[31:16]  = lane_merge(latch_q[31:16], DI, wm_c);
            OFS_CR4:      latch_d[15:0]   = lane_merge(latch_q[15:0], DI, wm_c);
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (wr_cr4_c) begin
               cmd_d              = latch_d;
               cmd_valid_d        = 1'b1;
               hirq_d[CMOK_BIT]   = 1'b0;
            end
`ifdef CD_PERIODIC_REPORT_EN
            else if (report_c) begin
               cr_d = STATUS | {8'h20, 56'h0};
            end
`endif
         end
         ISSUE: begin
            if (cmd_valid_q && CMD_READY) cmd_valid_d = 1'b0;
         end
         WAIT: begin
            if (RESP_VALID) begin
               cr_d   = RESP;
               hirq_d = hirq_d | RESP_HIRQ | 16'h0001;
            end
         end
         default: ;
      endcase

      irq_n_d = ~|(hirq_d & mask_d);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hirq_q      <= 16'hFFFF;
         mask_q      <= 16'h0000;
         cr_q        <= CR_RST;
         latch_q     <= CR_RST;
         cmd_q       <= '0;
         cmd_valid_q <= 1'b0;
         irq_n_q     <= 1'b1;
      end else if (CE_R) begin
         hirq_q      <= hirq_d;
         mask_q      <= mask_d;
         cr_q        <= cr_d;
         latch_q     <= latch_d;
         cmd_q       <= cmd_d;
         cmd_valid_q <= cmd_valid_d;
         irq_n_q     <= irq_n_d;
      end
   end

   // Host read mux; CR reads expose the response, not the command latch
   always_comb begin
      DO = '0;
      if (hit_c) begin
         case (ofs_c)
            OFS_HIRQ:     DO = hirq_q;
            OFS_HIRQMASK: DO = mask_q;
            OFS_CR1:      DO = cr_q[63:48];
            OFS_CR2:      DO = cr_q[47:32];
            OFS_CR3:      DO = cr_q[31:16];
            OFS_CR4:      DO = cr_q[15:0];
            default:      DO = '0;
         endcase
      end
   end

   assign IRQ_N     = irq_n_q;
   assign CMD_VALID = cmd_valid_q;
   assign CMD       = cmd_q;

endmodule

// File: tb/tb_cd_host_if.sv
// Scoreboard bench for cd_host_if: register window, command handshake, responses, reset abort.
module tb_cd_host_if;

`ifdef CD_PERIODIC_REPORT_EN
   localparam int unsigned TB_PERIOD = 16;
`else
   localparam int unsigned TB_PERIOD = 238000;
`endif

   logic         CLK = 1'b0;
   logic         RST_N;
   logic         CE_R;
   logic [25:1]  A;
   logic [15:0]  DI;
   logic [15:0]  DO;
   logic         CS_N, RD_N, WRU_N, WRL_N;
   logic         IRQ_N;
   logic         CMD_VALID;
   logic [63:0]  CMD;
   logic         CMD_READY;
   logic         RESP_VALID;
   logic [63:0]  RESP;
   logic [15:0]  RESP_HIRQ;
   logic [63:0]  STATUS;

   int n_vec = 0;
   int n_miscmp = 0;
   logic [63:0] exp_q[$];
   logic [15:0] rd;

   cd_host_if #(.PERIOD_CYC(TB_PERIOD)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .A(A), .DI(DI), .DO(DO),
      .CS_N(CS_N), .RD_N(RD_N), .WRU_N(WRU_N), .WRL_N(WRL_N), .IRQ_N(IRQ_N),
      .CMD_VALID(CMD_VALID), .CMD(CMD), .CMD_READY(CMD_READY),
      .RESP_VALID(RESP_VALID), .RESP(RESP), .RESP_HIRQ(RESP_HIRQ), .STATUS(STATUS)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miscmp++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus_wr(input logic [15:0] ofs, input logic [15:0] data,
                         input logic up, input logic lo);
      A = {10'h189, ofs[15:1]};
      DI = data; CS_N = 1'b0; WRU_N = !up; WRL_N = !lo;
      @(posedge CLK); #1;
      CS_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1;
   endtask

   task automatic bus_rd(input logic [15:0] ofs, output logic [15:0] d);
      A = {10'h189, ofs[15:1]};
      CS_N = 1'b0; RD_N = 1'b0;
      #1 d = DO;
      CS_N = 1'b1; RD_N = 1'b1;
   endtask

   task automatic rd_chk(input string tag, input logic [15:0] ofs, input logic [15:0] exp);
      logic [15:0] d;
      bus_rd(ofs, d);
      check(tag, 64'(d), 64'(exp));
   endtask

   task automatic resp_pulse(input logic [63:0] r, input logic [15:0] h);
      RESP = r; RESP_HIRQ = h; RESP_VALID = 1'b1;
      @(posedge CLK); #1;
      RESP_VALID = 1'b0;
   endtask

   // Bounded wait for every expected command to be consumed
   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      check("cmd_drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Scoreboard: compare each accepted command with the oldest expected one
   always @(negedge CLK) begin
      if (RST_N && CMD_VALID && CMD_READY) begin
         if (exp_q.size() == 0) check("cmd_unexpected", 64'd1, 64'd0);
         else                   check("cmd_payload", CMD, exp_q.pop_front());
      end
   end

   initial begin
      RST_N = 1'b0; CE_R = 1'b1; A = '0; DI = '0;
      CS_N = 1'b1; RD_N = 1'b1; WRU_N = 1'b1; WRL_N = 1'b1;
      CMD_READY = 1'b0; RESP_VALID = 1'b0; RESP = '0; RESP_HIRQ = '0;
      STATUS = 64'h0100_0002_0003_0004;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_irq_n", 64'(IRQ_N), 64'd1);
      check("rst_cmd_valid", 64'(CMD_VALID), 64'd0);
      check("rst_cmd", CMD, 64'd0);
      RST_N = 1'b1;

      rd_chk("rst_cr1", 16'h0018, 16'h0043);
      rd_chk("rst_cr2", 16'h001C, 16'h4442);
      rd_chk("rst_cr3", 16'h0020, 16'h4C4F);
      rd_chk("rst_cr4", 16'h0024, 16'h434B);
      rd_chk("rst_hirq", 16'h0008, 16'hFFFF);
      rd_chk("rst_mask", 16'h000C, 16'h0000);

      // Mask CMOK, then clear it from the host
      bus_wr(16'h000C, 16'h0001, 1'b1, 1'b1);
      check("irq_after_mask", 64'(IRQ_N), 64'd0);
      bus_wr(16'h0008, 16'hFFFE, 1'b1, 1'b1);
      rd_chk("hirq_clr", 16'h0008, 16'hFFFE);
      check("irq_after_clr", 64'(IRQ_N), 64'd1);

      // All-zero command, immediate accept, then response
      CMD_READY = 1'b1;
      bus_wr(16'h0018, 16'h0000, 1'b1, 1'b1);
      bus_wr(16'h001C, 16'h0000, 1'b1, 1'b1);
      bus_wr(16'h0020, 16'h0000, 1'b1, 1'b1);
      exp_q.push_back(64'h0);
      bus_wr(16'h0024, 16'h0000, 1'b1, 1'b1);
      check("cmd0_valid", 64'(CMD_VALID), 64'd1);
      drain();
      check("cmd0_valid_fall", 64'(CMD_VALID), 64'd0);
      repeat (2) @(posedge CLK);
      #1;
      resp_pulse(64'h0020_0000_0000_0000, 16'h0000);
      rd_chk("resp0_cr1", 16'h0018, 16'h0020);
      rd_chk("resp0_hirq", 16'h0008, 16'hFFFF);
      check("resp0_irq", 64'(IRQ_N), 64'd0);

      // Stalled back-end: command held, second CR4 write only updates latch
      CMD_READY = 1'b0;
      bus_wr(16'h0018, 16'h1111, 1'b1, 1'b1);
      bus_wr(16'h001C, 16'h2222, 1'b1, 1'b1);
      bus_wr(16'h0020, 16'h3333, 1'b1, 1'b1);
      exp_q.push_back(64'h1111_2222_3333_4444);
      bus_wr(16'h0024, 16'h4444, 1'b1, 1'b1);
      rd_chk("issue_cmok_clr", 16'h0008, 16'hFFFE);
      check("issue_irq", 64'(IRQ_N), 64'd1);
      for (int i = 0; i < 10; i++) begin
         if (i == 5) bus_wr(16'h0024, 16'h9999, 1'b1, 1'b1);
         else begin @(posedge CLK); #1; end
         check("stall_valid", 64'(CMD_VALID), 64'd1);
         check("stall_cmd", CMD, exp_q[0]);
      end
      rd_chk("stall_cmok", 16'h0008, 16'hFFFE);
      CMD_READY = 1'b1;
      drain();

      // Host clear and response set on the same edge: set wins
      RESP = 64'hAAAA_BBBB_CCCC_DDDD; RESP_HIRQ = 16'h0400; RESP_VALID = 1'b1;
      bus_wr(16'h0008, 16'h0000, 1'b1, 1'b1);
      RESP_VALID = 1'b0;
      rd_chk("race_hirq", 16'h0008, 16'h0401);
      rd_chk("race_cr4", 16'h0024, 16'hDDDD);
      check("race_irq", 64'(IRQ_N), 64'd0);

      // Upper-lane CR4 write issues the retained latch
      exp_q.push_back(64'h1111_2222_3333_7799);
      bus_wr(16'h0024, 16'h77AB, 1'b1, 1'b0);
      rd_chk("lane_issue_hirq", 16'h0008, 16'h0400);
      drain();
      resp_pulse(64'h0, 16'h0000);

      // Response strobe while idle must be ignored
      resp_pulse(64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFF);
      rd_chk("idle_resp_cr1", 16'h0018, 16'h0000);
      rd_chk("idle_resp_hirq", 16'h0008, 16'h0401);

      // Byte lanes on mask and HIRQ
      bus_wr(16'h000C, 16'h00FF, 1'b1, 1'b1);
      bus_wr(16'h000C, 16'h1234, 1'b1, 1'b0);
      rd_chk("mask_upper", 16'h000C, 16'h12FF);
      check("mask_irq", 64'(IRQ_N), 64'd0);
      bus_wr(16'h0008, 16'hFF00, 1'b0, 1'b1);
      rd_chk("hirq_lower", 16'h0008, 16'h0400);
      check("hirq_lower_irq", 64'(IRQ_N), 64'd1);

      // Clock enable low blocks writes
      CE_R = 1'b0;
      bus_wr(16'h000C, 16'hFFFF, 1'b1, 1'b1);
      CE_R = 1'b1;
      rd_chk("ce_hold_mask", 16'h000C, 16'h12FF);

      // Decode misses
      rd_chk("unmapped_ofs", 16'h0010, 16'h0000);
      A = {10'h188, 15'h000C}; CS_N = 1'b0;
      #1 check("wrong_base", 64'(DO), 64'd0);
      CS_N = 1'b1;

      // Periodic report timing after a response returns to idle
      exp_q.push_back(64'h1111_2222_3333_0000);
      bus_wr(16'h0024, 16'h0000, 1'b1, 1'b1);
      drain();
      resp_pulse(64'h0, 16'h0000);
      repeat (15) begin @(posedge CLK); #1; end
      rd_chk("report_early", 16'h0018, 16'h0000);
      @(posedge CLK); #1;
`ifdef CD_PERIODIC_REPORT_EN
      rd_chk("report_cr1", 16'h0018, 16'h2100);
      rd_chk("report_cr4", 16'h0024, 16'h0004);
`else
      rd_chk("no_report_cr1", 16'h0018, 16'h0000);
`endif
      rd_chk("report_hirq", 16'h0008, 16'h0401);

      // Reset during ISSUE aborts the command immediately
      CMD_READY = 1'b0;
      exp_q.push_back(64'h1111_2222_3333_5A5A);
      bus_wr(16'h0024, 16'h5A5A, 1'b1, 1'b1);
      check("abort_valid_pre", 64'(CMD_VALID), 64'd1);
      RST_N = 1'b0;
      exp_q.delete();
      #1;
      check("abort_valid", 64'(CMD_VALID), 64'd0);
      check("abort_irq", 64'(IRQ_N), 64'd1);
      rd_chk("abort_hirq", 16'h0008, 16'hFFFF);
      @(posedge CLK); #1;
      RST_N = 1'b1;

      // Reset during WAIT, then the FSM must accept a new command
      CMD_READY = 1'b1;
      bus_wr(16'h0018, 16'h0101, 1'b1, 1'b1);
      exp_q.push_back(64'h0101_4442_4C4F_0404);
      bus_wr(16'h0024, 16'h0404, 1'b1, 1'b1);
      drain();
      RST_N = 1'b0;
      exp_q.delete();
      #1;
      check("wait_rst_valid", 64'(CMD_VALID), 64'd0);
      rd_chk("wait_rst_cr1", 16'h0018, 16'h0043);
      @(posedge CLK); #1;
      RST_N = 1'b1;
      CMD_READY = 1'b0;
      exp_q.push_back(64'h0043_4442_4C4F_0505);
      bus_wr(16'h0024, 16'h0505, 1'b1, 1'b1);
      check("post_rst_issue", 64'(CMD_VALID), 64'd1);
      CMD_READY = 1'b1;
      drain();
      resp_pulse(64'h0, 16'h0000);
      check("final_queue", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
      $finish;
   end

endmodule
